// File: rtl/orologio_programmabile.sv
// -----------------------------------------------------------------------------
// orologio_programmabile
//   Time-of-day clock for the thermostat controller. An en-qualified prescaler
//   advances minutes, hours and day-of-week. A synchronous load sets hour and
//   minute. A small table of programmable alarms pulses on an exact hour:minute
//   match with the time reached by a minute advance.
//
// Parameters
//   PRESCALE   en-qualified clk cycles per minute advance (>=1)
//   ORE_MAX    hours per day, ora counts 0..ORE_MAX-1
//   MIN_MAX    minutes per hour, minuti counts 0..MIN_MAX-1
//   N_ALLARMI  number of alarm entries (>=2)
//
// Ports
//   clk       in   system clock, all state on rising edge
//   rst       in   asynchronous reset, active-high
//   en        in   count enable; low freezes prescaler and time
//   load      in   synchronous time load strobe
//   load_ora  in   hour value to load
//   load_min  in   minute value to load
//   al_we     in   alarm table write strobe
//   al_idx    in   alarm entry written
//   al_ora    in   alarm hour
//   al_min    in   alarm minute
//   al_on     in   alarm entry enable
//   ora       out  current hour
//   minuti    out  current minute
//   giorno    out  day of week 0..6
//   tick_min  out  1-cycle pulse on every minute advance
//   done      out  1-cycle pulse on day wrap
//   allarme   out  per-entry 1-cycle alarm match pulse
// -----------------------------------------------------------------------------
module orologio_programmabile #(
   parameter int PRESCALE  = 60,
   parameter int ORE_MAX   = 24,
   parameter int MIN_MAX   = 60,
   parameter int N_ALLARMI = 4,
   localparam int ORA_W = $clog2(ORE_MAX),
   localparam int MIN_W = $clog2(MIN_MAX),
   localparam int IDX_W = $clog2(N_ALLARMI)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 load,
   input  logic [ORA_W-1:0]     load_ora,
   input  logic [MIN_W-1:0]     load_min,
   input  logic                 al_we,
   input  logic [IDX_W-1:0]     al_idx,
   input  logic [ORA_W-1:0]     al_ora,
   input  logic [MIN_W-1:0]     al_min,
   input  logic                 al_on,
   output logic [ORA_W-1:0]     ora,
   output logic [MIN_W-1:0]     minuti,
   output logic [2:0]           giorno,
   output logic                 tick_min,
   output logic                 done,
   output logic [N_ALLARMI-1:0] allarme
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   // time state and registered pulses
   logic [PRE_W-1:0]     r_pre;
   logic [ORA_W-1:0]     r_ora;
   logic [MIN_W-1:0]     r_min;
   logic [2:0]           r_gio;
   logic                 r_tick;
   logic                 r_done;
   logic [N_ALLARMI-1:0] r_allarme;

   // alarm table
   logic [ORA_W-1:0]     r_al_ora [N_ALLARMI];
   logic [MIN_W-1:0]     r_al_min [N_ALLARMI];
   logic [N_ALLARMI-1:0] r_al_on;

   // next-time candidates for a minute advance
   logic                 w_pre_last;
   logic                 w_min_last;
   logic                 w_ora_last;
   logic                 w_wrap;
   logic [MIN_W-1:0]     w_min_nxt;
   logic [ORA_W-1:0]     w_ora_nxt;
   logic [2:0]           w_gio_nxt;
   logic                 w_load_ok;
   logic                 w_adv;
   logic                 w_idx_ok;
   logic [N_ALLARMI-1:0] w_match;

   always_comb begin
      w_pre_last = (32'(r_pre) == PRESCALE - 1);
      w_min_last = (32'(r_min) == MIN_MAX - 1);
      w_ora_last = (32'(r_ora) == ORE_MAX - 1);
      w_wrap     = w_min_last && w_ora_last;

      w_min_nxt = w_min_last ? '0 : r_min + MIN_W'(1);
      w_ora_nxt = r_ora;
      if (w_min_last) begin
         w_ora_nxt = w_ora_last ? '0 : r_ora + ORA_W'(1);
      end
      w_gio_nxt = r_gio;
      if (w_wrap) begin
         w_gio_nxt = (r_gio == 3'd6) ? 3'd0 : r_gio + 3'd1;
      end

      // an out-of-range load is dropped entirely, so it must not block counting
      w_load_ok = load && (32'(load_ora) < ORE_MAX) && (32'(load_min) < MIN_MAX);
      w_adv     = !w_load_ok && en && w_pre_last;
      w_idx_ok  = (32'(al_idx) < N_ALLARMI);

      // match against the post-advance time, using the table as it stands
      // before any same-cycle write
      for (int i = 0; i < N_ALLARMI; i++) begin
         w_match[i] = r_al_on[i] && (r_al_ora[i] == w_ora_nxt) && (r_al_min[i] == w_min_nxt);
      end
   end

   // time counters and output pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre     <= '0;
         r_ora     <= '0;
         r_min     <= '0;
         r_gio     <= '0;
         r_tick    <= 1'b0;
         r_done    <= 1'b0;
         r_allarme <= '0;
      end else begin
         r_tick    <= 1'b0;
         r_done    <= 1'b0;
         r_allarme <= '0;
         if (w_load_ok) begin
            r_ora <= load_ora;
            r_min <= load_min;
            r_pre <= '0;
         end else if (en) begin
            if (w_pre_last) begin
               r_pre     <= '0;
               r_min     <= w_min_nxt;
               r_ora     <= w_ora_nxt;
               r_gio     <= w_gio_nxt;
               r_tick    <= 1'b1;
               r_done    <= w_wrap;
               r_allarme <= w_adv ? w_match : '0;
            end else begin
               r_pre <= r_pre + PRE_W'(1);
            end
         end
      end
   end

   // alarm table writes, independent of en and load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_ALLARMI; i++) begin
            r_al_ora[i] <= '0;
            r_al_min[i] <= '0;
         end
         r_al_on <= '0;
      end else if (al_we && w_idx_ok) begin
         r_al_ora[al_idx] <= al_ora;
         r_al_min[al_idx] <= al_min;
         r_al_on[al_idx]  <= al_on;
      end
   end

   assign ora      = r_ora;
   assign minuti   = r_min;
   assign giorno   = r_gio;
   assign tick_min = r_tick;
   assign done     = r_done;
   assign allarme  = r_allarme;

endmodule

// File: tb/tb_orologio_programmabile.sv
// -----------------------------------------------------------------------------
// tb_orologio_programmabile
//   Scoreboard bench for orologio_programmabile (PRESCALE=2, 24h, 60min,
//   4 alarms). The driver applies one cycle of stimulus at each falling edge,
//   advances a minute-of-day reference model and queues the expected outputs;
//   the monitor pops one entry shortly after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_orologio_programmabile;

   localparam int PRESCALE = 2;
   localparam int ORE_MAX  = 24;
   localparam int MIN_MAX  = 60;
   localparam int NA       = 4;
   localparam int DAY      = ORE_MAX * MIN_MAX;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [4:0] load_ora = '0;
   logic [5:0] load_min = '0;
   logic       al_we = 1'b0;
   logic [1:0] al_idx = '0;
   logic [4:0] al_ora = '0;
   logic [5:0] al_min = '0;
   logic       al_on = 1'b0;
   logic [4:0] ora;
   logic [5:0] minuti;
   logic [2:0] giorno;
   logic       tick_min;
   logic       done;
   logic [3:0] allarme;

   orologio_programmabile #(
      .PRESCALE(PRESCALE), .ORE_MAX(ORE_MAX), .MIN_MAX(MIN_MAX), .N_ALLARMI(NA)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .load(load),
      .load_ora(load_ora), .load_min(load_min),
      .al_we(al_we), .al_idx(al_idx), .al_ora(al_ora), .al_min(al_min), .al_on(al_on),
      .ora(ora), .minuti(minuti), .giorno(giorno),
      .tick_min(tick_min), .done(done), .allarme(allarme)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] ora;
      logic [5:0] mi;
      logic [2:0] gio;
      logic       tick;
      logic       done;
      logic [3:0] al;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // reference model: time as minute-of-day, alarms as separate hour/minute
   int m_pre, m_t, m_day;
   int m_ao [NA];
   int m_am [NA];
   bit m_on [NA];

   // staged stimulus for the next cycle
   bit s_rst, s_en, s_load, s_we, s_aon;
   int s_lo, s_lm, s_idx, s_ao, s_am;

   task automatic model_reset();
      m_pre = 0; m_t = 0; m_day = 0;
      for (int i = 0; i < NA; i++) begin
         m_ao[i] = 0; m_am[i] = 0; m_on[i] = 0;
      end
   endtask

   task automatic cycle();
      exp_t e;
      @(negedge clk);
      rst      = s_rst;
      en       = s_en;
      load     = s_load;
      load_ora = 5'(s_lo);
      load_min = 6'(s_lm);
      al_we    = s_we;
      al_idx   = 2'(s_idx);
      al_ora   = 5'(s_ao);
      al_min   = 6'(s_am);
      al_on    = s_aon;
      e.tick = 0; e.done = 0; e.al = '0;
      if (s_rst) begin
         model_reset();
      end else begin
         if (s_load && s_lo < ORE_MAX && s_lm < MIN_MAX) begin
            m_t = s_lo * MIN_MAX + s_lm;
            m_pre = 0;
         end else if (s_en) begin
            m_pre++;
            if (m_pre == PRESCALE) begin
               m_pre = 0;
               m_t = (m_t + 1) % DAY;
               e.tick = 1;
               if (m_t == 0) begin
                  m_day = (m_day + 1) % 7;
                  e.done = 1;
               end
               for (int i = 0; i < NA; i++)
                  e.al[i] = m_on[i] && (m_ao[i] == m_t / MIN_MAX) && (m_am[i] == m_t % MIN_MAX);
            end
         end
         if (s_we && s_idx < NA) begin
            m_ao[s_idx] = s_ao; m_am[s_idx] = s_am; m_on[s_idx] = s_aon;
         end
      end
      e.ora = 5'(m_t / MIN_MAX);
      e.mi  = 6'(m_t % MIN_MAX);
      e.gio = 3'(m_day);
      q.push_back(e);
      s_load = 0;
      s_we   = 0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_load(input int h, input int m);
      s_load = 1; s_lo = h; s_lm = m;
      cycle();
   endtask

   task automatic wr_alarm(input int idx, input int h, input int m, input bit on);
      s_we = 1; s_idx = idx; s_ao = h; s_am = m; s_aon = on;
      cycle();
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (ora !== 0 || minuti !== 0 || giorno !== 0 || tick_min !== 0 || done !== 0 || allarme !== 0) begin
         errors++;
         $display("FAIL %s: got %0d:%0d d%0d tick=%b done=%b al=%b, want all zero",
                  name, ora, minuti, giorno, tick_min, done, allarme);
      end
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (ora !== e.ora || minuti !== e.mi || giorno !== e.gio ||
                tick_min !== e.tick || done !== e.done || allarme !== e.al) begin
               errors++;
               $display("FAIL cycle%0d: got %0d:%0d d%0d tick=%b done=%b al=%b, want %0d:%0d d%0d tick=%b done=%b al=%b",
                        cyc, ora, minuti, giorno, tick_min, done, allarme,
                        e.ora, e.mi, e.gio, e.tick, e.done, e.al);
            end
         end
      end
   end

   initial begin
      int tgt;
      model_reset();
      s_rst = 1; s_en = 0; s_load = 0; s_we = 0; s_aon = 0;
      s_lo = 0; s_lm = 0; s_idx = 0; s_ao = 0; s_am = 0;
      #1;
      check_zero("reset_state");

      // reset held 5 cycles, then free-running from 0:00
      run(5);
      s_rst = 0; s_en = 1;
      run(130);

      // day wrap from 23:59
      do_load(23, 59);
      run(4);

      // single alarm at 7:30
      wr_alarm(2, 7, 30, 1);
      do_load(7, 29);
      run(6);

      // two alarms at 0:00 coinciding with day wrap
      wr_alarm(0, 0, 0, 1);
      wr_alarm(3, 0, 0, 1);
      do_load(23, 58);
      run(6);

      // same-cycle write to a matching entry: match uses old contents
      do_load(0, 58);
      wr_alarm(1, 0, 59, 1);
      s_we = 1; s_idx = 1; s_ao = 1; s_am = 0; s_aon = 0;
      cycle();
      cycle();
      s_we = 1; s_idx = 1; s_ao = 1; s_am = 1; s_aon = 1;
      cycle();
      run(2);

      // out-of-range load ignored, valid load suppresses the tick
      do_load(5, 5);
      cycle();
      do_load(24, 10);
      run(2);
      do_load(5, 60);
      do_load(12, 0);
      run(3);

      // en toggling every cycle
      for (int i = 0; i < 20; i++) begin
         s_en = (i % 2 == 0);
         cycle();
      end
      s_en = 1;

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         s_en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 29) == 0) begin
            s_load = 1;
            if ($urandom_range(0, 3) == 0) begin
               s_lo = $urandom_range(0, 31); s_lm = $urandom_range(0, 63);
            end else begin
               s_lo = $urandom_range(0, 23); s_lm = $urandom_range(50, 59);
            end
         end
         if ($urandom_range(0, 9) == 0) begin
            tgt = (m_t + $urandom_range(1, 4)) % DAY;
            s_we = 1; s_idx = $urandom_range(0, NA - 1);
            s_ao = tgt / MIN_MAX; s_am = tgt % MIN_MAX;
            s_aon = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) s_am = $urandom_range(60, 63);
         end
         cycle();
      end

      // asynchronous reset in mid-count
      s_en = 1;
      run(3);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_reset_mid");
      model_reset();
      s_rst = 1;
      run(2);
      s_rst = 0;
      run(8);

      // drain
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
